// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared funct codes and sequencer state encoding for the HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module mips_cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_n,
  output logic [DATA_W-1:0] quo_n
);

  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  always_comb begin
    rem_sh = {rem, quo[DATA_W-1]};
    diff   = rem_sh - {1'b0, divisor};
    // rem < divisor on entry, so a non-borrowing difference always fits DATA_W bits
    if (!diff[DATA_W]) begin
      rem_n = diff[DATA_W-1:0];
      quo_n = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[DATA_W-1:0];
      quo_n = {quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer and HI/LO owner.
// Optional MIPS_MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module mips_cpu_muldiv_ctrl
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [5:0]        op_funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              op_ready,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mq_q, mq_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              is_div_q, is_div_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              is_signed;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   mul_sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] rem_n, quo_n;
`ifdef MIPS_MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;
`endif

  mips_cpu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem     (acc_q),
    .quo     (mq_q),
    .divisor (opb_q),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  always_comb begin
    is_signed = (op_funct == FUNCT_MULT) || (op_funct == FUNCT_DIV);
    mag_a     = (is_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    mag_b     = (is_signed && op_b[DATA_W-1]) ? -op_b : op_b;
    addend    = mq_q[0] ? opb_q : '0;
    mul_sum   = {1'b0, acc_q} + {1'b0, addend};
    prod      = {acc_q, mq_q};
`ifdef MIPS_MULDIV_FAST_MUL_EN
    fast_prod = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_funct)
            FUNCT_MULT, FUNCT_MULTU: begin
              is_div_d = 1'b0;
              neg_q_d  = is_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
              neg_r_d  = 1'b0;
              cnt_d    = CNT_W'(DATA_W - 1);
`ifdef MIPS_MULDIV_FAST_MUL_EN
              {acc_d, mq_d} = fast_prod;
              state_d  = FIX;
`else
              acc_d    = '0;
              mq_d     = mag_b;
              opb_d    = mag_a;
              state_d  = MUL;
`endif
            end
            FUNCT_DIV, FUNCT_DIVU: begin
              is_div_d = 1'b1;
              cnt_d    = CNT_W'(DATA_W - 1);
              if (op_b == '0) begin
                // Zero divisor reuses the divide fix-up with no negation: HI=op_a, LO=all ones
                acc_d   = op_a;
                mq_d    = '1;
                neg_q_d = 1'b0;
                neg_r_d = 1'b0;
                dz_d    = 1'b1;
                state_d = FIX;
              end else begin
                acc_d   = '0;
                mq_d    = mag_a;
                opb_d   = mag_b;
                neg_q_d = is_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                neg_r_d = is_signed & op_a[DATA_W-1];
                dz_d    = 1'b0;
                state_d = DIV;
              end
            end
            FUNCT_MTHI: hi_d = op_a;
            FUNCT_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mul_sum[DATA_W:1];
        mq_d  = {mul_sum[0], mq_q[DATA_W-1:1]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DIV: begin
        acc_d = rem_n;
        mq_d  = quo_n;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_q_q ? -mq_q : mq_q;
          hi_d = neg_r_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q_q ? -prod : prod;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    op_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    done     = done_q;
    div_zero = dz_q;
    hi_o     = hi_q;
    lo_o     = lo_q;
    if (op_funct == FUNCT_MFHI)      mf_data = hi_q;
    else if (op_funct == FUNCT_MFLO) mf_data = lo_q;
    else                             mf_data = '0;
  end

endmodule
